// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Constants and types shared by the Fibonacci-domain datapath blocks (binary to
// Zeckendorf encoder, Fibonacci adder, Fibonacci multiplier).
//
// Code format: bit k (1..31) of a CODE_W-bit word weighs F(k+1), with
// F(1)=F(2)=1. Bit 0 carries no weight and is always 0.
// -----------------------------------------------------------------------------
package fib_pkg;

  localparam int CODE_W = 32;
  localparam int OPND_W = 22;

  // Weights loaded at the start of a conversion: F(32) pairs with bit 31.
  localparam logic [OPND_W-1:0] FIB_W32 = 22'd2178309;
  localparam logic [OPND_W-1:0] FIB_W31 = 22'd1346269;

  // Largest value representable in the code: F(33)-1 = 0xAAAAAAAA decoded.
  localparam logic [OPND_W-1:0] FIB_MAX = 22'd3524577;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } fib_state_e;

  // A legal Zeckendorf code has bit 0 clear and no two adjacent ones.
  function automatic logic fib_code_legal(input logic [CODE_W-1:0] code);
    return (code[0] == 1'b0) && ((code & (code >> 1)) == '0);
  endfunction

endpackage

// File: rtl/bin2fib_encoder_if.sv
// -----------------------------------------------------------------------------
// bin2fib_encoder_if
// Request/response bundle of the binary to Zeckendorf encoder.
//   en_enc   : start request (requester -> encoder)
//   input_b  : unsigned binary operand, sampled with en_enc
//   out_fib  : Zeckendorf code result
//   enc_done : one-cycle completion pulse
//   enc_ovf  : operand exceeded FIB_MAX, valid with enc_done
// Modports: master = requester, slave = encoder.
// -----------------------------------------------------------------------------
interface bin2fib_encoder_if;
  import fib_pkg::*;

  logic              en_enc;
  logic [OPND_W-1:0] input_b;
  logic [CODE_W-1:0] out_fib;
  logic              enc_done;
  logic              enc_ovf;

  modport master (
    output en_enc,
    output input_b,
    input  out_fib,
    input  enc_done,
    input  enc_ovf
  );

  modport slave (
    input  en_enc,
    input  input_b,
    output out_fib,
    output enc_done,
    output enc_ovf
  );

endinterface

// File: rtl/fib_weight_step.sv
// -----------------------------------------------------------------------------
// fib_weight_step
// Walks a consecutive Fibonacci pair one position down: (hi,lo) -> (lo,hi-lo).
// Starting from (F(n+1),F(n)) this yields (F(n),F(n-1)); at the bottom of the
// walk (1,1) steps to (1,0), so the subtraction never goes negative.
//   hi_i, lo_i : current pair
//   hi_o, lo_o : next pair
// -----------------------------------------------------------------------------
module fib_weight_step
  import fib_pkg::*;
(
  input  logic [OPND_W-1:0] hi_i,
  input  logic [OPND_W-1:0] lo_i,
  output logic [OPND_W-1:0] hi_o,
  output logic [OPND_W-1:0] lo_o
);

  assign hi_o = lo_i;
  assign lo_o = hi_i - lo_i;

endmodule

// File: rtl/bin2fib_encoder.sv
// -----------------------------------------------------------------------------
// bin2fib_encoder
// Converts a 22-bit unsigned binary operand into a 32-bit Zeckendorf code by
// greedy selection, one code bit per cycle from bit 31 down to bit 1.
// Operands above FIB_MAX are flagged as overflow without scanning.
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : bin2fib_encoder_if.slave (en_enc, input_b, out_fib, enc_done, enc_ovf)
// Latency from the start edge to enc_done: 33 cycles normally, 2 on overflow.
// -----------------------------------------------------------------------------
module bin2fib_encoder
  import fib_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  bin2fib_encoder_if.slave     bus
);

  fib_state_e        state_q;
  logic [OPND_W-1:0] rem_q;
  logic [OPND_W-1:0] hi_q;
  logic [OPND_W-1:0] lo_q;
  logic [OPND_W-1:0] hi_d;
  logic [OPND_W-1:0] lo_d;
  logic [4:0]        k_q;
  logic [CODE_W-1:0] code_q;
  logic              ovf_q;
  logic [CODE_W-1:0] out_fib_q;
  logic              enc_done_q;
  logic              enc_ovf_q;
  logic              take_d;

  // The single comparator of the scan: does the current weight fit?
  assign take_d = (rem_q >= hi_q);

  fib_weight_step u_weight_step (
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (hi_d),
    .lo_o (lo_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      k_q        <= '0;
      code_q     <= '0;
      ovf_q      <= 1'b0;
      out_fib_q  <= '0;
      enc_done_q <= 1'b0;
      enc_ovf_q  <= 1'b0;
    end else begin
      enc_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.en_enc) begin
            rem_q   <= bus.input_b;
            hi_q    <= FIB_W32;
            lo_q    <= FIB_W31;
            k_q     <= 5'd31;
            code_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rem_q > FIB_MAX) begin
            ovf_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Greedy choice: taking the largest fitting weight guarantees the
          // next smaller weight cannot fit, so no adjacent ones can appear.
          if (take_d) begin
            code_q[k_q] <= 1'b1;
            rem_q       <= rem_q - hi_q;
          end
          hi_q <= hi_d;
          lo_q <= lo_d;
          k_q  <= k_q - 5'd1;
          if (k_q == 5'd1) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          out_fib_q  <= ovf_q ? '0 : code_q;
          enc_ovf_q  <= ovf_q;
          enc_done_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_fib  = out_fib_q;
  assign bus.enc_done = enc_done_q;
  assign bus.enc_ovf  = enc_ovf_q;

endmodule
